// File: rtl/wb_regfile_if.sv
// Bundles the MEM/WB write-back controls and the two ID-stage read ports of the register file.
// The master side is the pipeline and the slave side is wb_regfile.
interface wb_regfile_if;
  logic        jumpI;
  logic        memToRegI;
  logic        regWriteI;
  logic [31:0] readDataI;
  logic [31:0] aluResultI;
  logic [4:0]  writeRegistrerI;
  logic [31:0] linkAddrI;
  logic [4:0]  readReg1I;
  logic [4:0]  readReg2I;
  logic [31:0] readData1O;
  logic [31:0] readData2O;
  logic [31:0] wbDataO;
  logic [4:0]  wbRegO;
  logic [31:0] writeCountO;

  modport master (
    output jumpI, memToRegI, regWriteI, readDataI, aluResultI,
    output writeRegistrerI, linkAddrI, readReg1I, readReg2I,
    input  readData1O, readData2O, wbDataO, wbRegO, writeCountO
  );

  modport slave (
    input  jumpI, memToRegI, regWriteI, readDataI, aluResultI,
    input  writeRegistrerI, linkAddrI, readReg1I, readReg2I,
    output readData1O, readData2O, wbDataO, wbRegO, writeCountO
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back mux plus 32x32 architectural register file with write-first read bypass
// and a committed-write counter.
module wb_regfile #(
  parameter int          NREGS    = 32,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  logic [31:0] regFile_r [0:NREGS-1];
  logic [31:0] writeCount_r;
  logic [31:0] wbData_s;
  logic [4:0]  wbReg_s;
  logic        commit_s;
  logic [31:0] readData1_s;
  logic [31:0] readData2_s;

  // Write-back value/destination select and commit qualification.
  always_comb begin
    wbData_s = 32'd0;
    wbReg_s  = 5'd0;
    if (bus.jumpI) begin
      wbData_s = bus.linkAddrI;
      wbReg_s  = LINK_REG;
    end else if (bus.memToRegI) begin
      wbData_s = bus.readDataI;
      wbReg_s  = bus.writeRegistrerI;
    end else begin
      wbData_s = bus.aluResultI;
      wbReg_s  = bus.writeRegistrerI;
    end
    commit_s = bus.regWriteI && (wbReg_s != 5'd0) && !rst;
  end

  // Asynchronous read ports; r0 reads zero and a same-cycle commit wins over stored data.
  always_comb begin
    readData1_s = 32'd0;
    readData2_s = 32'd0;
    if (bus.readReg1I == 5'd0) begin
      readData1_s = 32'd0;
    end else if (commit_s && (wbReg_s == bus.readReg1I)) begin
      readData1_s = wbData_s;
    end else begin
      readData1_s = regFile_r[bus.readReg1I];
    end
    if (bus.readReg2I == 5'd0) begin
      readData2_s = 32'd0;
    end else if (commit_s && (wbReg_s == bus.readReg2I)) begin
      readData2_s = wbData_s;
    end else begin
      readData2_s = regFile_r[bus.readReg2I];
    end
  end

  // Register array and write counter; reset clears everything, including the unused r0 slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regFile_r[i] <= 32'd0;
      end
      writeCount_r <= 32'd0;
    end else if (commit_s) begin
      regFile_r[wbReg_s] <= wbData_s;
      writeCount_r       <= writeCount_r + 32'd1;
    end else begin
      writeCount_r <= writeCount_r;
    end
  end

  assign bus.readData1O  = readData1_s;
  assign bus.readData2O  = readData2_s;
  assign bus.wbDataO     = wbData_s;
  assign bus.wbRegO      = wbReg_s;
  assign bus.writeCountO = writeCount_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table followed by random traffic
// compared against an array-based reference model.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        jump;
    logic        m2r;
    logic        we;
    logic [31:0] rdData;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [31:0] link;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] eWb;
    logic [4:0]  eReg;
    logic [31:0] eCnt;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] mdl [32];
  logic [31:0] mdlCnt;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference read: zero register, then same-cycle commit, then stored value.
  function automatic logic [31:0] modelRead(input logic [4:0] idx, input logic r, input logic we,
                                            input logic [4:0] dest, input logic [31:0] data);
    if (idx == 5'd0) return 32'd0;
    if (!r && we && dest != 5'd0 && dest == idx) return data;
    return mdl[idx];
  endfunction

  // Drive one cycle, check comb outputs mid-cycle, then let the edge happen and update the model.
  task automatic runStep(input vec_t v, input bit useTable, input string tag);
    logic [31:0] d;
    logic [4:0]  dest;
    logic [31:0] e1, e2;
    rst                 = v.rst;
    bus.jumpI           = v.jump;
    bus.memToRegI       = v.m2r;
    bus.regWriteI       = v.we;
    bus.readDataI       = v.rdData;
    bus.aluResultI      = v.alu;
    bus.writeRegistrerI = v.wreg;
    bus.linkAddrI       = v.link;
    bus.readReg1I       = v.rr1;
    bus.readReg2I       = v.rr2;
    d    = v.jump ? v.link : (v.m2r ? v.rdData : v.alu);
    dest = v.jump ? 5'd31 : v.wreg;
    e1   = modelRead(v.rr1, v.rst, v.we, dest, d);
    e2   = modelRead(v.rr2, v.rst, v.we, dest, d);
    @(negedge clk);
    if (useTable) begin
      check({tag, " rd1"}, bus.readData1O, v.e1);
      check({tag, " rd2"}, bus.readData2O, v.e2);
      check({tag, " wbData"}, bus.wbDataO, v.eWb);
      check({tag, " wbReg"}, {27'd0, bus.wbRegO}, {27'd0, v.eReg});
      check({tag, " count"}, bus.writeCountO, v.eCnt);
    end else begin
      check({tag, " rd1"}, bus.readData1O, e1);
      check({tag, " rd2"}, bus.readData2O, e2);
      check({tag, " wbData"}, bus.wbDataO, d);
      check({tag, " wbReg"}, {27'd0, bus.wbRegO}, {27'd0, dest});
      check({tag, " count"}, bus.writeCountO, mdlCnt);
    end
    if (v.rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mdlCnt = 32'd0;
    end else if (v.we && dest != 5'd0) begin
      mdl[dest] = d;
      mdlCnt    = mdlCnt + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst   jmp   m2r   we    rdData         alu            wreg   link           rr1    rr2    e1             e2             eWb            eReg   eCnt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_00AB, 5'd5,  32'h0,         5'd5,  5'd5,  32'h0000_00AB, 32'h0000_00AB, 32'h0000_00AB, 5'd5,  32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         5'd5,  32'h0,         5'd5,  5'd0,  32'h0000_00AB, 32'h0,         32'h0,         5'd5,  32'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,         5'd7,  32'h0,         5'd7,  5'd31, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 5'd7,  32'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h1,         5'd7,  32'h0040_0010, 5'd7,  5'd31, 32'hDEAD_BEEF, 32'h0040_0010, 32'h0040_0010, 5'd31, 32'd2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         5'd3,  32'h0000_0099, 5'd31, 5'd7,  32'h0040_0010, 32'hDEAD_BEEF, 32'h0000_0099, 5'd31, 32'd3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         5'd0,  32'h0,         5'd31, 5'd3,  32'h0040_0010, 32'h0,         32'h0,         5'd0,  32'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_1234, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0,         32'h0000_1234, 5'd0,  32'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         5'd0,  32'h0,         5'd5,  5'd0,  32'h0000_00AB, 32'h0,         32'h0,         5'd0,  32'd3};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0055, 5'd3,  32'h0,         5'd3,  5'd5,  32'h0,         32'h0000_00AB, 32'h0000_0055, 5'd3,  32'd3};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0055, 5'd3,  32'h0,         5'd3,  5'd5,  32'h0000_0055, 32'h0,         32'h0000_0055, 5'd3,  32'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'hFFFF_0000, 5'd9,  32'h0,         5'd9,  5'd9,  32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 5'd9,  32'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         5'd0,  32'h0,         5'd9,  5'd3,  32'hFFFF_0000, 32'h0000_0055, 32'h0,         5'd0,  32'd2};

    // Initial reset with a write pending that must be discarded.
    bus.jumpI = 1'b0; bus.memToRegI = 1'b0; bus.regWriteI = 1'b1;
    bus.readDataI = 32'h0; bus.aluResultI = 32'hCAFE_F00D; bus.writeRegistrerI = 5'd4;
    bus.linkAddrI = 32'h0; bus.readReg1I = 5'd0; bus.readReg2I = 5'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.regWriteI = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdlCnt = 32'd0;
    for (int i = 0; i < 32; i++) begin
      bus.readReg1I = 5'(i);
      bus.readReg2I = 5'(31 - i);
      #1;
      check($sformatf("reset rd1[%0d]", i), bus.readData1O, 32'd0);
      check($sformatf("reset rd2[%0d]", 31 - i), bus.readData2O, 32'd0);
    end
    check("reset count", bus.writeCountO, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) runStep(vecs[i], 1'b1, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      vec_t r;
      r = vecs[0];
      r.rst    = ($urandom_range(0, 19) == 0);
      r.jump   = ($urandom_range(0, 4) == 0);
      r.m2r    = $urandom_range(0, 1) == 1;
      r.we     = ($urandom_range(0, 3) != 0);
      r.rdData = $urandom;
      r.alu    = $urandom;
      r.link   = $urandom;
      r.wreg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r.rr1    = ($urandom_range(0, 2) == 0) ? (r.jump ? 5'd31 : r.wreg) : 5'($urandom_range(0, 31));
      r.rr2    = ($urandom_range(0, 2) == 0) ? r.rr1 : 5'($urandom_range(0, 31));
      runStep(r, 1'b0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
